// File: rtl/btn_event_pkg.sv
// Shared encodings and default timing for the button event generator.
package btn_event_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOLD   = 2'd1;
  localparam logic [1:0] ST_REPEAT = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE   = ST_IDLE,
    S_HOLD   = ST_HOLD,
    S_REPEAT = ST_REPEAT
  } state_t;

  localparam int unsigned LONG_MS_DEF   = 1000;
  localparam int unsigned REPEAT_MS_DEF = 200;
  localparam int unsigned CNT_W_DEF     = 11;

endpackage

// File: rtl/btn_event_ch.sv
// One button channel: press/release edges, long-press timer and auto-repeat.
module btn_event_ch
  import btn_event_pkg::*;
#(
  parameter int unsigned LONG_MS   = LONG_MS_DEF,
  parameter int unsigned REPEAT_MS = REPEAT_MS_DEF,
  parameter bit          REPEAT_EN = 1'b1,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic press_pulse,
  output logic release_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic held
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_d, release_d, long_d, repeat_d, held_d;

  // State, counter and all outputs registered together
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      long_pulse    <= 1'b0;
      repeat_pulse  <= 1'b0;
      held          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      press_pulse   <= press_d;
      release_pulse <= release_d;
      long_pulse    <= long_d;
      repeat_pulse  <= repeat_d;
      held          <= held_d;
    end
  end

  // Next state; a release always takes priority over a terminal tick
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (btn) begin
          state_d = S_HOLD;
          cnt_d   = '0;
          press_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (!btn) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (tick) begin
          if (cnt_q == LONG_LAST) begin
            state_d = S_REPEAT;
            cnt_d   = '0;
            long_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      S_REPEAT: begin
        if (!btn) begin
          state_d   = S_IDLE;
          cnt_d     = '0;
          release_d = 1'b1;
        end else if (tick) begin
          if (cnt_q == REPEAT_LAST) begin
            cnt_d    = '0;
            repeat_d = REPEAT_EN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    held_d = (state_d != S_IDLE);
  end

endmodule

// File: rtl/btn_event.sv
// Per-button press/release/long/repeat event pulses from debounced levels.
module btn_event
  import btn_event_pkg::*;
#(
  parameter int unsigned N_BTN     = 5,
  parameter int unsigned LONG_MS   = LONG_MS_DEF,
  parameter int unsigned REPEAT_MS = REPEAT_MS_DEF,
  parameter bit          REPEAT_EN = 1'b1,
  parameter int unsigned CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic [N_BTN-1:0] btn_db,
  output logic [N_BTN-1:0] press_pulse,
  output logic [N_BTN-1:0] release_pulse,
  output logic [N_BTN-1:0] long_pulse,
  output logic [N_BTN-1:0] repeat_pulse,
  output logic [N_BTN-1:0] held
);

  // Independent channel per button, all sharing the tick strobe
  for (genvar i = 0; i < int'(N_BTN); i++) begin : g_ch
    btn_event_ch #(
      .LONG_MS  (LONG_MS),
      .REPEAT_MS(REPEAT_MS),
      .REPEAT_EN(REPEAT_EN),
      .CNT_W    (CNT_W)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .btn          (btn_db[i]),
      .press_pulse  (press_pulse[i]),
      .release_pulse(release_pulse[i]),
      .long_pulse   (long_pulse[i]),
      .repeat_pulse (repeat_pulse[i]),
      .held         (held[i])
    );
  end

endmodule

// File: tb/tb_btn_event.sv
// Directed bench for btn_event: vector table plus long-hold, boundary and reset sequences.
module tb_btn_event;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic [4:0] btn_db;
  logic [4:0] press, rel, lng, rep, held;
  logic [4:0] nr_press, nr_rel, nr_lng, nr_rep, nr_held;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  btn_event #(.N_BTN(5), .LONG_MS(10), .REPEAT_MS(4), .REPEAT_EN(1'b1), .CNT_W(11)) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn_db(btn_db),
    .press_pulse(press), .release_pulse(rel), .long_pulse(lng),
    .repeat_pulse(rep), .held(held)
  );

  btn_event #(.N_BTN(5), .LONG_MS(10), .REPEAT_MS(4), .REPEAT_EN(1'b0), .CNT_W(11)) dut_nr (
    .clk(clk), .rst(rst), .tick(tick), .btn_db(btn_db),
    .press_pulse(nr_press), .release_pulse(nr_rel), .long_pulse(nr_lng),
    .repeat_pulse(nr_rep), .held(nr_held)
  );

  typedef struct {
    int         n;
    logic [4:0] btn;
    logic       tk;
    logic [4:0] p, r, l, rp, h;
  } vec_t;

  vec_t tab [0:15];

  task automatic chk(input string nm, input logic [4:0] act, input logic [4:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_dut(input string tag, input logic [4:0] p, input logic [4:0] r,
                         input logic [4:0] l, input logic [4:0] rp, input logic [4:0] h);
    chk({tag, " press"}, press, p);
    chk({tag, " release"}, rel, r);
    chk({tag, " long"}, lng, l);
    chk({tag, " repeat"}, rep, rp);
    chk({tag, " held"}, held, h);
  endtask

  task automatic cyc(input logic [4:0] b, input logic t);
    @(negedge clk);
    btn_db = b;
    tick   = t;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [4:0] acc;
    logic [4:0] e_l, e_r;
    logic       tk;

    // Channel 0: tick ignored in idle, press, 5 ticks, release; then ch2 one-cycle tap
    tab[0]  = '{1, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tab[1]  = '{1, 5'b00001, 1'b0, 5'b00001, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[2]  = '{1, 5'b00001, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[3]  = '{3, 5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[4]  = '{1, 5'b00001, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[5]  = '{3, 5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[6]  = '{1, 5'b00001, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[7]  = '{3, 5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[8]  = '{1, 5'b00001, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[9]  = '{3, 5'b00001, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[10] = '{1, 5'b00001, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00001};
    tab[11] = '{1, 5'b00000, 1'b0, 5'b00000, 5'b00001, 5'b00000, 5'b00000, 5'b00000};
    tab[12] = '{2, 5'b00000, 1'b1, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};
    tab[13] = '{1, 5'b00100, 1'b0, 5'b00100, 5'b00000, 5'b00000, 5'b00000, 5'b00100};
    tab[14] = '{1, 5'b00000, 1'b0, 5'b00000, 5'b00100, 5'b00000, 5'b00000, 5'b00000};
    tab[15] = '{1, 5'b00000, 1'b0, 5'b00000, 5'b00000, 5'b00000, 5'b00000, 5'b00000};

    // Reset, then 50 idle cycles with ticks
    rst = 1'b1; btn_db = '0; tick = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_dut("reset", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    acc = '0;
    for (int i = 0; i < 50; i++) begin
      cyc(5'b0, (i % 4) == 3);
      acc = acc | press | rel | lng | rep | held;
    end
    chk("idle outputs", acc, 5'b0);

    // Table-driven vectors
    for (int v = 0; v < 16; v++) begin
      for (int k = 0; k < tab[v].n; k++) begin
        cyc(tab[v].btn, tab[v].tk);
        chk_dut($sformatf("vec%0d", v), tab[v].p, tab[v].r, tab[v].l, tab[v].rp, tab[v].h);
      end
    end

    // Channels 2 and 3 held 30 ticks: long after tick 10, repeats after 14,18,22,26,30
    cyc(5'b01100, 1'b0);
    chk_dut("hold30 press", 5'b01100, 5'b0, 5'b0, 5'b0, 5'b01100);
    chk("hold30 nr press", nr_press, 5'b01100);
    for (int k = 1; k <= 30; k++) begin
      for (int j = 0; j < 4; j++) begin
        tk = (j == 3);
        cyc(5'b01100, tk);
        e_l = (tk && k == 10) ? 5'b01100 : 5'b0;
        e_r = (tk && k > 10 && ((k - 10) % 4) == 0) ? 5'b01100 : 5'b0;
        chk_dut($sformatf("hold30 k%0d", k), 5'b0, 5'b0, e_l, e_r, 5'b01100);
        chk($sformatf("hold30 nr long k%0d", k), nr_lng, e_l);
        chk($sformatf("hold30 nr repeat k%0d", k), nr_rep, 5'b0);
        chk($sformatf("hold30 nr held k%0d", k), nr_held, 5'b01100);
      end
    end
    cyc(5'b0, 1'b0);
    chk_dut("hold30 release", 5'b0, 5'b01100, 5'b0, 5'b0, 5'b0);
    chk("hold30 nr release", nr_rel, 5'b01100);
    cyc(5'b0, 1'b0);
    chk("hold30 release once", rel, 5'b0);

    // Channel 1: press on a tick (not counted), release on the 10th counted tick
    cyc(5'b00010, 1'b1);
    chk_dut("coinc press", 5'b00010, 5'b0, 5'b0, 5'b0, 5'b00010);
    acc = '0;
    for (int k = 1; k <= 9; k++) begin
      for (int j = 0; j < 4; j++) begin
        cyc(5'b00010, j == 3);
        acc = acc | lng | rel;
      end
    end
    repeat (3) begin
      cyc(5'b00010, 1'b0);
      acc = acc | lng | rel;
    end
    chk("coinc no early long", acc, 5'b0);
    cyc(5'b0, 1'b1);
    chk_dut("coinc release", 5'b0, 5'b00010, 5'b0, 5'b0, 5'b0);
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      cyc(5'b0, 1'b1);
      acc = acc | press | rel | lng | rep | held;
    end
    chk("coinc idle after", acc, 5'b0);

    // Channels 0 and 4 pressed 3 ticks apart: long pulses 3 ticks apart
    cyc(5'b00001, 1'b0);
    chk_dut("stagger press0", 5'b00001, 5'b0, 5'b0, 5'b0, 5'b00001);
    for (int t = 1; t <= 13; t++) begin
      for (int j = 0; j < 4; j++) begin
        tk = (j == 3);
        cyc((t >= 4) ? 5'b10001 : 5'b00001, tk);
        e_l = (tk && t == 10) ? 5'b00001 : ((tk && t == 13) ? 5'b10000 : 5'b0);
        chk_dut($sformatf("stagger t%0d j%0d", t, j),
                (t == 4 && j == 0) ? 5'b10000 : 5'b0, 5'b0, e_l, 5'b0,
                (t >= 4) ? 5'b10001 : 5'b00001);
      end
    end

    // Reset mid-hold: outputs clear at once, no release; press again on exit with buttons down
    #2;
    rst = 1'b1;
    #1;
    chk_dut("midhold reset", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    chk("midhold reset nr held", nr_held, 5'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_dut("midhold in reset", 5'b0, 5'b0, 5'b0, 5'b0, 5'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk_dut("post reset press", 5'b10001, 5'b0, 5'b0, 5'b0, 5'b10001);
    cyc(5'b10001, 1'b0);
    chk_dut("post reset hold", 5'b0, 5'b0, 5'b0, 5'b0, 5'b10001);
    cyc(5'b0, 1'b0);
    chk_dut("final release", 5'b0, 5'b10001, 5'b0, 5'b0, 5'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
